// File: rtl/branch_target_buffer_pkg.sv
// Shared types for the branch target buffer: entry layout, lookup result,
// EX-to-fetch update bundle and the 2-bit direction counter encoding.
package branch_target_buffer_pkg;

  typedef enum logic [1:0] {
    CNT_STRONG_NT = 2'b00,
    CNT_WEAK_NT   = 2'b01,
    CNT_WEAK_T    = 2'b10,
    CNT_STRONG_T  = 2'b11
  } btb_cnt_e;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [63:0] target_address;
    logic [1:0]  cnt;
  } btb_entry_t;

  typedef struct packed {
    logic        valid;
    logic        taken;
    logic [63:0] target_address;
  } branchpredict_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic        taken;
    logic [63:0] target_address;
  } btb_update_t;

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Combinational lookup from fetch, registered update from EX, flush clears valid bits.
module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter int NR_ENTRIES = 8,
  parameter int VLEN       = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic [VLEN-1:0] vpc_i,
  output logic            predict_valid_o,
  output logic            predict_taken_o,
  output logic [VLEN-1:0] predict_target_o,
  input  logic            update_valid_i,
  input  logic [VLEN-1:0] update_pc_i,
  input  logic            update_taken_i,
  input  logic [VLEN-1:0] update_target_i
);

  localparam int IDX_W = $clog2(NR_ENTRIES);

  function automatic btb_cnt_e sat_inc(input btb_cnt_e c);
    btb_cnt_e n;
    n = c;
    unique case (c)
      CNT_STRONG_NT: n = CNT_WEAK_NT;
      CNT_WEAK_NT:   n = CNT_WEAK_T;
      CNT_WEAK_T:    n = CNT_STRONG_T;
      CNT_STRONG_T:  n = CNT_STRONG_T;
      default:       n = c;
    endcase
    return n;
  endfunction

  function automatic btb_cnt_e sat_dec(input btb_cnt_e c);
    btb_cnt_e n;
    n = c;
    unique case (c)
      CNT_STRONG_NT: n = CNT_STRONG_NT;
      CNT_WEAK_NT:   n = CNT_STRONG_NT;
      CNT_WEAK_T:    n = CNT_WEAK_NT;
      CNT_STRONG_T:  n = CNT_WEAK_T;
      default:       n = c;
    endcase
    return n;
  endfunction

  logic [IDX_W-1:0] w_lookup_idx;
  logic [IDX_W-1:0] w_update_idx;
  logic [NR_ENTRIES-1:0] w_valid;
  logic [VLEN-1:0]  w_pc     [NR_ENTRIES];
  logic [VLEN-1:0]  w_target [NR_ENTRIES];
  logic [1:0]       w_cnt    [NR_ENTRIES];
  logic             w_hit;

  // pc[1:0] never contribute to the index; they still take part in the tag.
  assign w_lookup_idx = vpc_i[IDX_W+1:2];
  assign w_update_idx = update_pc_i[IDX_W+1:2];

  genvar gi;
  generate
    for (gi = 0; gi < NR_ENTRIES; gi++) begin : g_entry
      logic            r_valid;
      logic [VLEN-1:0] r_pc;
      logic [VLEN-1:0] r_target;
      btb_cnt_e        r_cnt;
      logic            w_sel;
      logic            w_upd_hit;

      assign w_sel     = update_valid_i && (w_update_idx == IDX_W'(gi));
      assign w_upd_hit = r_valid && (r_pc == update_pc_i);

      // Flush has priority over any update landing in the same cycle.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_valid  <= 1'b0;
          r_pc     <= '0;
          r_target <= '0;
          r_cnt    <= CNT_STRONG_NT;
        end else if (flush_i) begin
          r_valid <= 1'b0;
        end else if (w_sel) begin
          if (w_upd_hit) begin
            if (update_taken_i) begin
              r_cnt    <= sat_inc(r_cnt);
              r_target <= update_target_i;
            end else begin
              r_cnt <= sat_dec(r_cnt);
            end
          end else if (update_taken_i) begin
            r_valid  <= 1'b1;
            r_pc     <= update_pc_i;
            r_target <= update_target_i;
            r_cnt    <= CNT_WEAK_T;
          end
        end
      end

      assign w_valid[gi]  = r_valid;
      assign w_pc[gi]     = r_pc;
      assign w_target[gi] = r_target;
      assign w_cnt[gi]    = r_cnt;
    end
  endgenerate

  // Lookup reads the registered state only, so an update is seen one cycle later.
  assign w_hit            = w_valid[w_lookup_idx] && (w_pc[w_lookup_idx] == vpc_i);
  assign predict_valid_o  = w_hit;
  assign predict_taken_o  = w_hit && w_cnt[w_lookup_idx][1];
  assign predict_target_o = w_hit ? w_target[w_lookup_idx] : '0;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed and randomised checks of branch_target_buffer against a
// table-of-records reference model with plain counter arithmetic.
module tb_branch_target_buffer;

  localparam int N = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic [63:0] vpc_i;
  logic        predict_valid_o;
  logic        predict_taken_o;
  logic [63:0] predict_target_o;
  logic        update_valid_i;
  logic [63:0] update_pc_i;
  logic        update_taken_i;
  logic [63:0] update_target_i;

  int checks = 0;
  int errors = 0;

  // Reference model: one record per slot, counter kept as an integer 0..3.
  logic        m_valid [N];
  logic [63:0] m_pc    [N];
  logic [63:0] m_tgt   [N];
  int          m_cnt   [N];

  branch_target_buffer #(.NR_ENTRIES(N), .VLEN(64)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .flush_i          (flush_i),
    .vpc_i            (vpc_i),
    .predict_valid_o  (predict_valid_o),
    .predict_taken_o  (predict_taken_o),
    .predict_target_o (predict_target_o),
    .update_valid_i   (update_valid_i),
    .update_pc_i      (update_pc_i),
    .update_taken_i   (update_taken_i),
    .update_target_i  (update_target_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int slot(input logic [63:0] pc);
    return int'((pc / 4) % N);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_pc[i]    = '0;
      m_tgt[i]   = '0;
      m_cnt[i]   = 0;
    end
  endtask

  task automatic model_apply(input logic uv, input logic [63:0] upc, input logic ut,
                             input logic [63:0] utgt, input logic fl);
    int s;
    s = slot(upc);
    if (fl) begin
      for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    end else if (uv) begin
      if (m_valid[s] && m_pc[s] == upc) begin
        if (ut) begin
          m_cnt[s] = (m_cnt[s] + 1 > 3) ? 3 : m_cnt[s] + 1;
          m_tgt[s] = utgt;
        end else begin
          m_cnt[s] = (m_cnt[s] - 1 < 0) ? 0 : m_cnt[s] - 1;
        end
      end else if (ut) begin
        m_valid[s] = 1'b1;
        m_pc[s]    = upc;
        m_tgt[s]   = utgt;
        m_cnt[s]   = 2;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_lookup(input string tag);
    int  s;
    logic hit;
    s   = slot(vpc_i);
    hit = m_valid[s] && (m_pc[s] == vpc_i);
    chk({tag, ".valid"},  64'(predict_valid_o),  64'(hit));
    chk({tag, ".taken"},  64'(predict_taken_o),  64'(hit && m_cnt[s] >= 2));
    chk({tag, ".target"}, predict_target_o,      hit ? m_tgt[s] : 64'h0);
  endtask

  // One clock: drive, check pre-update lookup at negedge, apply model at posedge.
  task automatic cycle(input string tag, input logic uv, input logic [63:0] upc,
                       input logic ut, input logic [63:0] utgt, input logic fl,
                       input logic [63:0] vpc);
    update_valid_i  = uv;
    update_pc_i     = upc;
    update_taken_i  = ut;
    update_target_i = utgt;
    flush_i         = fl;
    vpc_i           = vpc;
    @(negedge clk_i);
    check_lookup(tag);
    @(posedge clk_i);
    model_apply(uv, upc, ut, utgt, fl);
    #1;
    update_valid_i = 1'b0;
    flush_i        = 1'b0;
    $display("txn %s upd=%0b pc=%h taken=%0b tgt=%h flush=%0b look=%h hit=%0b",
             tag, uv, upc, ut, utgt, fl, vpc, predict_valid_o);
  endtask

  task automatic look(input string tag, input logic [63:0] vpc);
    cycle(tag, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, vpc);
  endtask

  initial begin
    logic [6:0]  walk_dir;
    logic [6:0]  walk_exp;
    logic [63:0] pc;
    logic [63:0] vp;
    rst_ni = 1'b0;
    flush_i = 1'b0;
    vpc_i = 64'h8000_0010;
    update_valid_i = 1'b0;
    update_pc_i = '0;
    update_taken_i = 1'b0;
    update_target_i = '0;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Reset state
    look("reset", 64'h8000_0010);
    chk("reset.valid_const", 64'(predict_valid_o), 64'h0);

    // Allocation: same-cycle lookup sees old contents
    cycle("alloc", 1'b1, 64'h8000_0010, 1'b1, 64'h8000_0100, 1'b0, 64'h8000_0010);
    look("alloc_next", 64'h8000_0010);
    chk("alloc.target_const", predict_target_o, 64'h8000_0100);

    // Counter walk: 3x not-taken then 4x taken
    walk_dir = 7'b1111000;
    walk_exp = 7'b1110000;
    for (int i = 0; i < 7; i++) begin
      cycle("walk_upd", 1'b1, 64'h8000_0010, walk_dir[i], 64'h8000_0100, 1'b0, 64'h8000_0010);
      look("walk_look", 64'h8000_0010);
      chk("walk.taken_const", 64'(predict_taken_o), 64'(walk_exp[i]));
      chk("walk.valid_const", 64'(predict_valid_o), 64'h1);
    end

    // Alias replaces slot 4; tag compare includes pc[1:0]
    cycle("alias", 1'b1, 64'h8000_0030, 1'b1, 64'h8000_0200, 1'b0, 64'h8000_0030);
    look("alias_old", 64'h8000_0010);
    look("alias_new", 64'h8000_0030);
    chk("alias.target_const", predict_target_o, 64'h8000_0200);
    look("alias_lowbits", 64'h8000_0012);

    // Not-taken miss allocates nothing; flush beats a same-cycle update
    cycle("nt_miss", 1'b1, 64'h8000_0044, 1'b0, 64'h8000_0300, 1'b0, 64'h8000_0044);
    look("nt_miss_look", 64'h8000_0044);
    cycle("flush", 1'b1, 64'h8000_0018, 1'b1, 64'h8000_0400, 1'b1, 64'h8000_0030);
    look("flush_a", 64'h8000_0018);
    look("flush_b", 64'h8000_0030);
    chk("flush.valid_const", 64'(predict_valid_o), 64'h0);

    // Fill every slot, then asynchronous reset between edges
    for (int i = 0; i < N; i++) begin
      pc = 64'h8000_0000 + 64'(i * 4);
      cycle("fill", 1'b1, pc, 1'b1, 64'h9000_0000 + 64'(i * 16), 1'b0, pc);
    end
    look("fill_look", 64'h8000_000C);
    chk("fill.valid_const", 64'(predict_valid_o), 64'h1);
    @(negedge clk_i);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("async_rst.valid",  64'(predict_valid_o),  64'h0);
    chk("async_rst.taken",  64'(predict_taken_o),  64'h0);
    chk("async_rst.target", predict_target_o,      64'h0);
    model_reset();
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    for (int i = 0; i < N; i++) look("post_rst", 64'h8000_0000 + 64'(i * 4));

    // Randomised traffic over a small PC pool to force hits, aliases and tag mismatches
    for (int n = 0; n < 400; n++) begin
      pc = 64'h8000_0000 | 64'($urandom_range(0, 23) * 4);
      if ($urandom_range(0, 9) == 0) pc = pc | 64'($urandom_range(1, 3));
      vp = 64'h8000_0000 | 64'($urandom_range(0, 23) * 4);
      if ($urandom_range(0, 3) == 0) vp = pc;
      cycle("rand", ($urandom_range(0, 9) < 7), pc, 1'($urandom_range(0, 1)),
            {32'h0, $urandom}, ($urandom_range(0, 49) == 0), vp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
